// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID-stage read ports, in-flight destinations and the
// branch-resolved strobe in; stall/flush/forwarding controls out.
interface hazard_ctrl_if #(
    parameter int unsigned AW  = 4,
    parameter int unsigned NRD = 2
) ();

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD-1:0]    rd_use;
    logic              ex_regwrite;
    logic [AW-1:0]     ex_wa;
    logic              mem_regwrite;
    logic [AW-1:0]     mem_wa;
    logic              wb_regwrite;
    logic [AW-1:0]     wb_wa;
    logic              br_taken;

    logic              stall_if;
    logic              stall_id;
    logic              flush_id;
    logic              flush_ex;
    logic [2*NRD-1:0]  fwd_sel;
    logic [1:0]        stall_cnt;
    logic [2:0]        flush_cnt;

    // Pipeline side: presents register usage, consumes hazard controls.
    modport master (
        output rd_addr, rd_use,
        output ex_regwrite, ex_wa, mem_regwrite, mem_wa, wb_regwrite, wb_wa,
        output br_taken,
        input  stall_if, stall_id, flush_id, flush_ex, fwd_sel, stall_cnt, flush_cnt
    );

    // Hazard controller side.
    modport slave (
        input  rd_addr, rd_use,
        input  ex_regwrite, ex_wa, mem_regwrite, mem_wa, wb_regwrite, wb_wa,
        input  br_taken,
        output stall_if, stall_id, flush_id, flush_ex, fwd_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the pipelined core. Compares ID-stage source registers
// against EX/MEM/WB destinations and produces operand-forwarding selects,
// counted stalls and counted branch flushes. Multi-cycle stall/flush timing is
// held in two down-counters; all outputs are combinational from the inputs and
// those counters.
module hazard_ctrl #(
    parameter int unsigned AW       = 4,
    parameter int unsigned NRD      = 2,
    parameter int unsigned FWD      = 1,
    parameter int unsigned BR_FLUSH = 2,
    parameter int unsigned PC_ADDR  = 15
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam logic [2:0]    FLUSH_RELOAD = 3'(BR_FLUSH - 1);
    localparam logic [AW-1:0] PC_REG       = AW'(PC_ADDR);

    logic [1:0]       stall_cnt_q, stall_cnt_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;

    logic [NRD-1:0]   m_ex, m_mem, m_wb;
    logic             any_ex, any_mem, any_wb;
    logic             detect_en;
    logic             hazard;
    logic             new_stall;
    logic [1:0]       stall_len;
    logic             stall_active;
    logic             flush_active;
    logic [2*NRD-1:0] fwd_sel;

    // A read port depends on a stage when it is used, the stage writes, the
    // addresses agree and the register is not the PC.
    function automatic logic port_match(input logic [AW-1:0] addr,
                                        input logic          used,
                                        input logic          we,
                                        input logic [AW-1:0] wa);
        return used && we && (addr == wa) && (addr != PC_REG);
    endfunction

    // Per-port match against each in-flight stage.
    always_comb begin
        m_ex  = '0;
        m_mem = '0;
        m_wb  = '0;
        for (int i = 0; i < NRD; i++) begin
            m_ex[i]  = port_match(bus.rd_addr[i*AW +: AW], bus.rd_use[i],
                                  bus.ex_regwrite, bus.ex_wa);
            m_mem[i] = port_match(bus.rd_addr[i*AW +: AW], bus.rd_use[i],
                                  bus.mem_regwrite, bus.mem_wa);
            m_wb[i]  = port_match(bus.rd_addr[i*AW +: AW], bus.rd_use[i],
                                  bus.wb_regwrite, bus.wb_wa);
        end
        any_ex  = |m_ex;
        any_mem = |m_mem;
        any_wb  = |m_wb;
    end

    // Hazard detection and stall length; the nearest producer sets the length.
    always_comb begin
        detect_en = (stall_cnt_q == 2'd0) && (flush_cnt_q == 3'd0);
        if (FWD != 0) begin
            // Only a value still in EX cannot be forwarded in time.
            hazard    = any_ex;
            stall_len = 2'd1;
        end else begin
            hazard = any_ex || any_mem || any_wb;
            if (any_ex) begin
                stall_len = 2'd3;
            end else if (any_mem) begin
                stall_len = 2'd2;
            end else begin
                stall_len = 2'd1;
            end
        end
        // A taken branch squashes the instruction that would have stalled.
        new_stall    = detect_en && hazard && !bus.br_taken;
        flush_active = bus.br_taken || (flush_cnt_q != 3'd0);
        stall_active = !bus.br_taken && ((stall_cnt_q != 2'd0) || new_stall);
    end

    // Counter next-state: branch reloads the flush and cancels any stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.br_taken) begin
            flush_cnt_d = FLUSH_RELOAD;
            stall_cnt_d = 2'd0;
        end else begin
            if (flush_cnt_q != 3'd0) begin
                flush_cnt_d = flush_cnt_q - 3'd1;
            end
            if (stall_cnt_q != 2'd0) begin
                stall_cnt_d = stall_cnt_q - 2'd1;
            end else if (new_stall) begin
                stall_cnt_d = stall_len - 2'd1;
            end
        end
    end

    // Forwarding selects: MEM beats WB; a port waiting on EX reads the regfile.
    always_comb begin
        fwd_sel = '0;
        if ((FWD != 0) && (stall_cnt_q == 2'd0)) begin
            for (int i = 0; i < NRD; i++) begin
                if (m_ex[i]) begin
                    fwd_sel[2*i +: 2] = 2'b00;
                end else if (m_mem[i]) begin
                    fwd_sel[2*i +: 2] = 2'b01;
                end else if (m_wb[i]) begin
                    fwd_sel[2*i +: 2] = 2'b10;
                end
            end
        end
    end

    // Output drive; reset forces everything quiet without waiting for a clock.
    always_comb begin
        bus.stall_if  = stall_active && !reset;
        bus.stall_id  = stall_active && !reset;
        bus.flush_id  = flush_active && !reset;
        bus.flush_ex  = (stall_active || flush_active) && !reset;
        bus.fwd_sel   = reset ? '0 : fwd_sel;
        bus.stall_cnt = stall_cnt_q;
        bus.flush_cnt = flush_cnt_q;
    end

    // Stall and flush counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 2'd0;
            flush_cnt_q <= 3'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (forwarding/BR_FLUSH=2, stall-only/
// BR_FLUSH=2, stall-only/BR_FLUSH=3) share one stimulus stream. Directed
// vectors push hand-computed expectations into a queue; a negedge monitor
// pops and compares.
module tb_hazard_ctrl;

    localparam int D_F1 = 0;
    localparam int D_F0 = 1;
    localparam int D_B3 = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rd_addr;
    logic [1:0] rd_use;
    logic       ex_regwrite, mem_regwrite, wb_regwrite, br_taken;
    logic [3:0] ex_wa, mem_wa, wb_wa;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        int          cyc;
        int          dut;
        logic [12:0] exp;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [12:0] mon_act;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hazard_ctrl_if #(.AW(4), .NRD(2)) if1 ();
    hazard_ctrl_if #(.AW(4), .NRD(2)) if0 ();
    hazard_ctrl_if #(.AW(4), .NRD(2)) if3 ();

    assign if1.rd_addr = rd_addr;      assign if0.rd_addr = rd_addr;      assign if3.rd_addr = rd_addr;
    assign if1.rd_use = rd_use;        assign if0.rd_use = rd_use;        assign if3.rd_use = rd_use;
    assign if1.ex_regwrite = ex_regwrite;
    assign if0.ex_regwrite = ex_regwrite;
    assign if3.ex_regwrite = ex_regwrite;
    assign if1.ex_wa = ex_wa;          assign if0.ex_wa = ex_wa;          assign if3.ex_wa = ex_wa;
    assign if1.mem_regwrite = mem_regwrite;
    assign if0.mem_regwrite = mem_regwrite;
    assign if3.mem_regwrite = mem_regwrite;
    assign if1.mem_wa = mem_wa;        assign if0.mem_wa = mem_wa;        assign if3.mem_wa = mem_wa;
    assign if1.wb_regwrite = wb_regwrite;
    assign if0.wb_regwrite = wb_regwrite;
    assign if3.wb_regwrite = wb_regwrite;
    assign if1.wb_wa = wb_wa;          assign if0.wb_wa = wb_wa;          assign if3.wb_wa = wb_wa;
    assign if1.br_taken = br_taken;    assign if0.br_taken = br_taken;    assign if3.br_taken = br_taken;

    hazard_ctrl #(.AW(4), .NRD(2), .FWD(1), .BR_FLUSH(2), .PC_ADDR(15)) u_f1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    hazard_ctrl #(.AW(4), .NRD(2), .FWD(0), .BR_FLUSH(2), .PC_ADDR(15)) u_f0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    hazard_ctrl #(.AW(4), .NRD(2), .FWD(0), .BR_FLUSH(3), .PC_ADDR(15)) u_b3 (
        .clk(clk), .reset(reset), .bus(if3)
    );

    // Packed as {stall_if, stall_id, flush_id, flush_ex, fwd_sel[3:0], stall_cnt, flush_cnt}.
    function automatic logic [12:0] actual(input int d);
        case (d)
            D_F1:    return {if1.stall_if, if1.stall_id, if1.flush_id, if1.flush_ex,
                             if1.fwd_sel, if1.stall_cnt, if1.flush_cnt};
            D_F0:    return {if0.stall_if, if0.stall_id, if0.flush_id, if0.flush_ex,
                             if0.fwd_sel, if0.stall_cnt, if0.flush_cnt};
            default: return {if3.stall_if, if3.stall_id, if3.flush_id, if3.flush_ex,
                             if3.fwd_sel, if3.stall_cnt, if3.flush_cnt};
        endcase
    endfunction

    task automatic exp_out(input int d, input logic sif, input logic sid, input logic fid,
                           input logic fex, input logic [3:0] fwd, input logic [1:0] scnt,
                           input logic [2:0] fcnt, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.dut  = d;
        e.exp  = {sif, sid, fid, fex, fwd, scnt, fcnt};
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic exp_zero(input int d, input string name);
        exp_out(d, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 3'd0, name);
    endtask

    task automatic exp_stall(input int d, input logic [1:0] scnt, input string name);
        exp_out(d, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, scnt, 3'd0, name);
    endtask

    task automatic exp_flush(input int d, input logic [1:0] scnt, input logic [2:0] fcnt,
                             input string name);
        exp_out(d, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, scnt, fcnt, name);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_addr      = 8'h00;
        rd_use       = 2'b00;
        ex_regwrite  = 1'b0;
        ex_wa        = 4'd0;
        mem_regwrite = 1'b0;
        mem_wa       = 4'd0;
        wb_regwrite  = 1'b0;
        wb_wa        = 4'd0;
        br_taken     = 1'b0;
    endtask

    // EX-stage producer of r3 with port 0 reading r3.
    task automatic ex_hazard();
        idle();
        ex_regwrite = 1'b1;
        ex_wa       = 4'd3;
        rd_addr     = 8'h03;
        rd_use      = 2'b01;
    endtask

    // Monitor: compares every expectation registered for the current cycle.
    always @(negedge clk) begin
        while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
            mon_e   = sbq.pop_front();
            mon_act = actual(mon_e.dut);
            n_cmp++;
            if (mon_act !== mon_e.exp) begin
                n_bad++;
                $display("FAIL %s dut%0d cyc%0d: got %b want %b (si sd fi fx fwd4 sc2 fc3)",
                         mon_e.name, mon_e.dut, cyc, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        cycle();
        exp_zero(D_F1, "reset_f1"); exp_zero(D_F0, "reset_f0"); exp_zero(D_B3, "reset_b3");
        cycle(); reset = 1'b0;
        exp_zero(D_F1, "post_reset_f1"); exp_zero(D_F0, "post_reset_f0");

        // EX hazard, producer then moves to MEM and WB.
        cycle(); ex_hazard();
        exp_stall(D_F1, 2'd0, "f1_ex_stall"); exp_stall(D_F0, 2'd0, "f0_ex_c1");
        cycle(); ex_regwrite = 1'b0; mem_regwrite = 1'b1; mem_wa = 4'd3;
        exp_out(D_F1, 0, 0, 0, 0, 4'b0001, 2'd0, 3'd0, "f1_fwd_mem");
        exp_stall(D_F0, 2'd2, "f0_ex_c2");
        cycle(); mem_regwrite = 1'b0; wb_regwrite = 1'b1; wb_wa = 4'd3;
        exp_out(D_F1, 0, 0, 0, 0, 4'b0010, 2'd0, 3'd0, "f1_fwd_wb");
        exp_stall(D_F0, 2'd1, "f0_ex_c3");
        cycle(); idle();
        exp_zero(D_F0, "f0_ex_end");

        // Port 1 matches both MEM and WB.
        cycle(); rd_addr = 8'h50; rd_use = 2'b10;
        mem_regwrite = 1'b1; mem_wa = 4'd5; wb_regwrite = 1'b1; wb_wa = 4'd5;
        exp_out(D_F1, 0, 0, 0, 0, 4'b0100, 2'd0, 3'd0, "f1_mem_prio");
        exp_stall(D_F0, 2'd0, "f0_mem_c1");
        cycle();
        exp_stall(D_F0, 2'd1, "f0_mem_c2");
        cycle(); idle();
        exp_zero(D_F0, "f0_mem_end"); exp_zero(D_F1, "f1_idle");

        // WB-only match.
        cycle(); rd_addr = 8'h07; rd_use = 2'b01; wb_regwrite = 1'b1; wb_wa = 4'd7;
        exp_stall(D_F0, 2'd0, "f0_wb_c1");
        exp_out(D_F1, 0, 0, 0, 0, 4'b0010, 2'd0, 3'd0, "f1_wb_fwd");
        cycle(); idle();
        exp_zero(D_F0, "f0_wb_end");

        // PC reads and an unused port never match.
        cycle(); rd_addr = 8'h9F; rd_use = 2'b01; ex_regwrite = 1'b1; ex_wa = 4'd15;
        mem_regwrite = 1'b1; mem_wa = 4'd9; wb_regwrite = 1'b1; wb_wa = 4'd15;
        exp_zero(D_F0, "f0_pc_unused"); exp_zero(D_F1, "f1_pc_unused");

        // Branch flush, 2 vs 3 cycles; detection is off while flushing.
        cycle(); idle(); br_taken = 1'b1;
        exp_flush(D_F0, 2'd0, 3'd0, "br2_c1"); exp_flush(D_B3, 2'd0, 3'd0, "br3_c1");
        cycle(); ex_hazard();
        exp_flush(D_F0, 2'd0, 3'd1, "br2_c2_nostall");
        exp_flush(D_B3, 2'd0, 3'd2, "br3_c2");
        exp_flush(D_F1, 2'd0, 3'd1, "f1_br_nostall");
        cycle(); idle();
        exp_zero(D_F0, "br2_end"); exp_flush(D_B3, 2'd0, 3'd1, "br3_c3");
        cycle();
        exp_zero(D_B3, "br3_end");

        // Back-to-back branches reload the flush counter.
        cycle(); br_taken = 1'b1;
        exp_flush(D_B3, 2'd0, 3'd0, "reload_c1");
        cycle();
        exp_flush(D_B3, 2'd0, 3'd2, "reload_c2");
        cycle(); br_taken = 1'b0;
        exp_flush(D_B3, 2'd0, 3'd2, "reload_c3"); exp_flush(D_F0, 2'd0, 3'd1, "br2_reload");
        cycle();
        exp_flush(D_B3, 2'd0, 3'd1, "reload_c4"); exp_zero(D_F0, "br2_reload_end");
        cycle();
        exp_zero(D_B3, "reload_end");

        // Branch in the second stall cycle cancels the stall.
        cycle(); ex_hazard();
        exp_stall(D_F0, 2'd0, "brov_c1");
        cycle(); br_taken = 1'b1;
        exp_flush(D_F0, 2'd2, 3'd0, "brov_br");
        cycle(); idle();
        exp_flush(D_F0, 2'd0, 3'd1, "brov_flush2");
        cycle();
        exp_zero(D_F0, "brov_end");

        // Asynchronous reset mid-stall, then a full restart.
        cycle(); ex_hazard();
        exp_stall(D_F0, 2'd0, "rst_c1");
        cycle();
        exp_stall(D_F0, 2'd2, "rst_c2");
        cycle(); reset = 1'b1;
        exp_zero(D_F0, "rst_async"); exp_zero(D_F1, "rst_async_f1");
        cycle(); reset = 1'b0;
        exp_stall(D_F0, 2'd0, "rst_restart_c1");
        cycle();
        exp_stall(D_F0, 2'd2, "rst_restart_c2");
        cycle(); idle();
        exp_stall(D_F0, 2'd1, "rst_restart_c3");
        cycle();
        exp_zero(D_F0, "rst_restart_end");

        cycle();
        cycle();
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Sequential, parametrised hazard controller for the pipelined ARM core. Sits beside the ID stage. It compares ID-stage source registers against in-flight destinations in EX/MEM/WB and drives operand-forwarding selects, counted stalls, and counted branch flushes. All stall and flush timing lives in registered counters rather than combinational feedback.

## Interface
Parameters:
- `AW`, default 4: register address width.
- `NRD`, default 2: number of ID-stage read ports.
- `FWD`, default 1: 1 enables forwarding; 0 selects stall-only mode.
- `BR_FLUSH`, default 2: cycles of flush after a taken branch; legal range 1–7.
- `PC_ADDR`, default 15: register address that never produces a hazard (PC).

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `rd_addr`, in, NRD*AW: ID source addresses; port i is at [i*AW +: AW].
- `rd_use`, in, NRD: per-port valid bit; 0 means the port is not read.
- `ex_regwrite`, in, 1: the EX-stage instruction writes a register.
- `ex_wa`, in, AW: EX-stage destination address.
- `mem_regwrite`, in, 1: the MEM-stage instruction writes a register.
- `mem_wa`, in, AW: MEM-stage destination address.
- `wb_regwrite`, in, 1: the WB-stage instruction writes a register.
- `wb_wa`, in, AW: WB-stage destination address.
- `br_taken`, in, 1: branch resolved taken in EX this cycle.
- `stall_if`, out, 1: hold the PC.
- `stall_id`, out, 1: hold the IF/ID register.
- `flush_id`, out, 1: bubble the IF/ID register.
- `flush_ex`, out, 1: bubble the ID/EX register.
- `fwd_sel`, out, 2*NRD: per-port operand source. 00 = register file, 01 = MEM result, 10 = WB result.
- `stall_cnt`, out, 2: remaining stall cycles (debug).
- `flush_cnt`, out, 3: remaining flush cycles (debug).

## Operation
Match rule: port i matches stage S when all of the following hold:
- `rd_use[i]` is 1.
- `regwrite_S` is 1.
- `rd_addr_i == wa_S`.
- `rd_addr_i != PC_ADDR`.

Stall detection runs only when `stall_cnt == 0` and `flush_cnt == 0`.

FWD=1:
- Any port matching EX is a hazard with stall length L = 1.
- For ports not stalled: `fwd_sel` = 01 if the port matches MEM, else 10 if it matches WB, else 00. MEM has priority over WB.
- The MEM result bus carries final data, including load data.

FWD=0:
- `fwd_sel` is always 0.
- L depends on the nearest matching stage: EX → 3, MEM → 2, WB → 1. The nearest stage wins.
- The register file is not write-through, so a WB match needs 1 stall cycle.

On a stall hazard in detection cycle d:
- `stall_if`, `stall_id` and `flush_ex` are 1 in cycle d (combinational).
- `stall_cnt` loads L−1.
- While `stall_cnt > 0`, the same three outputs stay 1 and the counter decrements by 1 per cycle.
- Total stall length is exactly L cycles.

On `br_taken` in cycle t:
- `flush_id` and `flush_ex` are 1 in cycle t (combinational).
- `flush_cnt` loads BR_FLUSH−1.
- Both outputs stay 1 while `flush_cnt > 0`, decrementing by 1 per cycle.
- `stall_if` and `stall_id` are 0 throughout the flush.

Simultaneous events:
- `br_taken` has priority over a stall. It clears `stall_cnt` to 0 in the same edge, because the stalled instruction is on the wrong path.
- A `br_taken` during an active flush reloads `flush_cnt` with BR_FLUSH−1.
- Neither counter wraps. Both saturate at 0.

## Timing
- Reset: `stall_cnt` = 0 and `flush_cnt` = 0. With all inputs at 0, every output is 0.
- Reset is asynchronous. Asserting it mid-stall or mid-flush drops all outputs in that same cycle, with no clock edge needed.
- Outputs are combinational from the inputs and the counters, with zero-cycle detect latency. Counters update on the rising edge of `clk`.
- `fwd_sel` is valid in the same cycle as `rd_addr` and is 0 while `stall_cnt > 0`.

## Test plan
- **FWD=1, EX hazard:** `ex_regwrite`=1, `ex_wa`=3, port0 = r3 (`rd_use[0]`=1) → stall/flush_ex high for exactly 1 cycle. Next cycle, with the producer in MEM (`mem_wa`=3), `fwd_sel[1:0]`=01.
- **FWD=0, EX hazard:** same EX match → stall high for 3 consecutive cycles, `stall_cnt` sequence 2,1,0. MEM-only match → 2 cycles. WB-only match → 1 cycle.
- **PC and unused ports:** read r15 while `ex_wa`=15, plus a matching address with `rd_use`=0 → no stall, `fwd_sel`=0.
- **Branch flush, BR_FLUSH=2:** `br_taken` pulse → `flush_id`/`flush_ex` high 2 cycles, `stall_if`=0. Repeat with BR_FLUSH=3 → 3 cycles.
- **Branch overrides stall:** FWD=0, EX hazard starts; `br_taken` arrives in stall cycle 2 → `stall_cnt`→0 at the next edge, then 2 flush cycles.
- **Reset mid-operation:** assert `reset` during a 3-cycle stall → all outputs 0 immediately. After release, the first match restarts a full L.
